// File: rtl/prng_wb_fifo.sv
// -----------------------------------------------------------------------------
// prng_wb_fifo
//
// Wishbone front end for the Caravel user-area PRNG. A single-cycle xorshift32
// generator feeds a 4-deep FIFO. Firmware controls it through four registers:
//   0x0 CTRL   : bit0 EN (R/W), bit1 FLUSH (write-1 pulse, reads 0); lane 0 only
//   0x4 SEED   : byte-merged write loads the state and flushes the FIFO;
//                a merged value of 0 loads 1; read returns the current state
//   0x8 DATA   : read pops the FIFO head (0 + sticky UNDERFLOW when empty)
//   0xC STATUS : bit0 EMPTY, bit1 FULL, bits[4:2] COUNT, bit5 UNDERFLOW (W1C)
//
// Ports
//   wb_clk_i     system clock, rising edge
//   wb_rst_ni    asynchronous active-low reset
//   wbs_cyc_i    Wishbone cycle
//   wbs_stb_i    Wishbone strobe
//   wbs_we_i     write enable
//   wbs_sel_i    byte lane selects
//   wbs_adr_i    byte address; block decoded on [31:4], register on [3:2]
//   wbs_dat_i    write data
//   wbs_ack_o    single-cycle acknowledge (registered)
//   wbs_dat_o    registered read data, valid while ack is high
//   rnd_level_o  registered FIFO occupancy 0..4
// -----------------------------------------------------------------------------
module prng_wb_fifo #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2468
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [2:0]  rnd_level_o
);

  typedef enum logic [0:0] {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_SEED   = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;
  localparam logic [2:0] FIFO_DEPTH = 3'd4;

  // One xorshift32 step: <<13, >>17, <<5, truncated to 32 bits.
  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // Byte-lane merge of write data over the current state.
  function automatic logic [31:0] sel_merge(input logic [31:0] cur,
                                            input logic [31:0] wdat,
                                            input logic [3:0]  sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = sel[b] ? wdat[8*b +: 8] : cur[8*b +: 8];
    end
    return m;
  endfunction

  // Registers
  bus_state_e  bus_q, bus_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  level_q, level_d;
  logic        en_q, en_d;
  logic        unf_q, unf_d;
  logic [31:0] gen_q, gen_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [31:0] mem_q [4];

  // Combinational signals
  logic        adr_hit_s;
  logic        access_s;
  logic [1:0]  reg_idx_s;
  logic        ctrl_wr_s, seed_wr_s, stat_wr_s, data_rd_s;
  logic        flush_s, pop_s, push_s;
  logic [31:0] gen_next_s;
  logic [31:0] seed_merged_s;
  logic [31:0] seed_load_s;
  logic [31:0] rd_mux_s;
  logic [31:0] status_s;
  logic        unused_s;

  assign unused_s  = ^wbs_adr_i[1:0];
  assign adr_hit_s = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_idx_s = wbs_adr_i[3:2];

  // Bus FSM next state; an access is taken only from IDLE so acks never abut.
  always_comb begin
    bus_d    = bus_q;
    access_s = 1'b0;
    case (bus_q)
      BUS_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i && adr_hit_s) begin
          access_s = 1'b1;
          bus_d    = BUS_ACK;
        end else begin
          bus_d    = BUS_IDLE;
        end
      end
      BUS_ACK: begin
        bus_d = BUS_IDLE;
      end
      default: begin
        bus_d = BUS_IDLE;
      end
    endcase
  end

  // Register access decode and FIFO/generator control strobes.
  always_comb begin
    ctrl_wr_s     = access_s && wbs_we_i && (reg_idx_s == REG_CTRL) && wbs_sel_i[0];
    seed_wr_s     = access_s && wbs_we_i && (reg_idx_s == REG_SEED);
    stat_wr_s     = access_s && wbs_we_i && (reg_idx_s == REG_STATUS);
    data_rd_s     = access_s && !wbs_we_i && (reg_idx_s == REG_DATA);
    flush_s       = (ctrl_wr_s && wbs_dat_i[1]) || seed_wr_s;
    pop_s         = data_rd_s && (count_q != 3'd0);
    // A pop in the same cycle frees the slot the push needs, even when full.
    push_s        = en_q && ((count_q < FIFO_DEPTH) || pop_s) && !flush_s;
    gen_next_s    = xorshift32(gen_q);
    seed_merged_s = sel_merge(gen_q, wbs_dat_i, wbs_sel_i);
    if (seed_merged_s == 32'h0000_0000) begin
      seed_load_s = 32'h0000_0001;
    end else begin
      seed_load_s = seed_merged_s;
    end
  end

  // Read-data multiplexer; STATUS and DATA reflect pre-edge FIFO state.
  always_comb begin
    status_s = {26'd0, unf_q, count_q,
                (count_q == FIFO_DEPTH), (count_q == 3'd0)};
    rd_mux_s = 32'h0000_0000;
    case (reg_idx_s)
      REG_CTRL:   rd_mux_s = {31'd0, en_q};
      REG_SEED:   rd_mux_s = gen_q;
      REG_DATA: begin
        if (pop_s) begin
          rd_mux_s = mem_q[rd_ptr_q];
        end else begin
          rd_mux_s = 32'h0000_0000;
        end
      end
      REG_STATUS: rd_mux_s = status_s;
      default:    rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Next-state for control, generator, FIFO pointers and bus outputs.
  always_comb begin
    ack_d    = access_s;
    rdata_d  = 32'h0000_0000;
    en_d     = en_q;
    unf_d    = unf_q;
    gen_d    = gen_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (access_s && !wbs_we_i) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = 32'h0000_0000;
    end

    if (ctrl_wr_s) begin
      en_d = wbs_dat_i[0];
    end else begin
      en_d = en_q;
    end

    if (data_rd_s && (count_q == 3'd0)) begin
      unf_d = 1'b1;
    end else if (stat_wr_s && wbs_dat_i[5]) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end

    if (seed_wr_s) begin
      gen_d = seed_load_s;
    end else if (push_s) begin
      gen_d = gen_next_s;
    end else begin
      gen_d = gen_q;
    end

    if (flush_s) begin
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      count_d  = 3'd0;
    end else begin
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + 2'd1;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + 2'd1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end

    level_d = count_d;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      bus_q    <= BUS_IDLE;
      ack_q    <= 1'b0;
      rdata_q  <= 32'h0000_0000;
      level_q  <= 3'd0;
      en_q     <= 1'b0;
      unf_q    <= 1'b0;
      gen_q    <= SEED_DEFAULT;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      bus_q    <= bus_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      level_q  <= level_d;
      en_q     <= en_d;
      unf_q    <= unf_d;
      gen_q    <= gen_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; the pushed word is the generator's next state.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= gen_next_s;
      end else begin
        mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
      end
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = rdata_q;
  assign rnd_level_o = level_q;

endmodule

// File: tb/tb_prng_wb_fifo.sv
// -----------------------------------------------------------------------------
// Self-checking bench for prng_wb_fifo. A queue-based reference model tracks
// the register block; a compare process checks ack, read data and level on
// every falling edge; directed steps add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_prng_wb_fifo;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_SEED = BASE + 32'h4;
  localparam logic [31:0] A_DATA = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, dat = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  prng_wb_fifo dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .rnd_level_o(level)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_q[$];
  logic [31:0] m_gen;
  bit          m_en, m_unf, m_ack, m_was_rd;
  logic [31:0] m_rdat;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_gen    = 32'hACE1_2468;
    m_en     = 1'b0;
    m_unf    = 1'b0;
    m_ack    = 1'b0;
    m_was_rd = 1'b0;
    m_rdat   = 32'h0;
  endtask

  task automatic model_step();
    int          cnt;
    logic [2:0]  c3;
    logic [1:0]  idx;
    bit          hit, rd, pop, flush, push;
    logic [31:0] val, merged;
    cnt = m_q.size();
    c3  = cnt[2:0];
    idx = adr[3:2];
    hit = cyc && stb && (adr[31:4] == BASE[31:4]) && !m_ack;
    rd  = hit && !we;
    pop = rd && (idx == 2'd2) && (cnt > 0);
    flush = hit && we && (((idx == 2'd0) && sel[0] && dat[1]) || (idx == 2'd1));
    push  = m_en && ((cnt < 4) || pop) && !flush;
    case (idx)
      2'd0: val = {31'd0, m_en};
      2'd1: val = m_gen;
      2'd2: val = (cnt > 0) ? m_q[0] : 32'h0;
      default: val = {26'd0, m_unf, c3, (cnt == 4), (cnt == 0)};
    endcase
    m_ack    = hit;
    m_was_rd = rd;
    if (rd) m_rdat = val;
    if (rd && idx == 2'd2 && cnt == 0) m_unf = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      m_gen = xs(m_gen);
      m_q.push_back(m_gen);
    end
    if (hit && we) begin
      case (idx)
        2'd0: if (sel[0]) m_en = dat[0];
        2'd1: begin
          for (int b = 0; b < 4; b++)
            merged[8*b +: 8] = sel[b] ? dat[8*b +: 8] : m_gen[8*b +: 8];
          m_gen = (merged == 32'h0) ? 32'h1 : merged;
        end
        2'd3: if (dat[5]) m_unf = 1'b0;
        default: ;
      endcase
    end
    if (flush) m_q.delete();
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("ack_vs_model", {31'd0, ack}, {31'd0, m_ack});
      check("level_vs_model", {29'd0, level}, m_q.size());
      if (m_ack && m_was_rd) check("rdata_vs_model", rdat, m_rdat);
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wb_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
    bit got;
    got = 1'b0;
    r   = 32'h0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack) begin
        got = 1'b1;
        r   = rdat;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wb_timeout addr=%h actual=no_ack expected=ack", a);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb_access(1'b1, a, d, s, r);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
    wb_access(1'b0, a, 32'h0, 4'hF, r);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] r, prev;
    int acks;
    bit got;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ack", {31'd0, ack}, 32'h0);
    check("reset_level", {29'd0, level}, 32'h0);
    rst_n = 1'b1;

    wb_read(A_STAT, r); check("post_reset_status", r, 32'h0000_0001);
    wb_read(A_SEED, r); check("post_reset_seed", r, 32'hACE1_2468);
    wb_read(A_CTRL, r); check("post_reset_ctrl", r, 32'h0);

    // Seed 1, enable, fill
    wb_write(A_SEED, 32'h1, 4'hF);
    wb_write(A_CTRL, 32'h1, 4'hF);
    repeat (6) @(negedge clk);
    wb_read(A_STAT, r); check("full_status", r, 32'h0000_0012);
    wb_read(A_DATA, r); check("data0_seed1", r, 32'h0004_2021);
    wb_read(A_DATA, r); check("data1_seed1", r, 32'h0408_0601);

    // Disable + flush, underflow, W1C
    wb_write(A_CTRL, 32'h2, 4'hF);
    wb_read(A_STAT, r); check("flushed_status", r, 32'h0000_0001);
    wb_read(A_DATA, r); check("underflow_data", r, 32'h0);
    wb_read(A_STAT, r); check("underflow_status", r, 32'h0000_0021);
    wb_write(A_STAT, 32'h20, 4'hF);
    wb_read(A_STAT, r); check("underflow_cleared", r, 32'h0000_0001);

    // Zero seed maps to 1
    wb_write(A_SEED, 32'h0, 4'hF);
    wb_read(A_SEED, r); check("seed_zero_to_one", r, 32'h0000_0001);
    wb_read(A_STAT, r); check("seed_zero_empty", r, 32'h0000_0001);

    // Partial seed write flushes and merges lane 0 only
    wb_write(A_SEED, 32'h1234_5678, 4'hF);
    wb_write(A_CTRL, 32'h1, 4'hF);
    repeat (6) @(negedge clk);
    wb_write(A_CTRL, 32'h0, 4'hF);
    wb_read(A_STAT, r); check("full_before_merge", r, 32'h0000_0012);
    wb_read(A_SEED, prev);
    wb_write(A_SEED, 32'h0000_00FF, 4'b0001);
    wb_read(A_SEED, r); check("seed_byte_merge", r, {prev[31:8], 8'hFF});
    wb_read(A_STAT, r); check("seed_merge_flush", r, 32'h0000_0001);

    // Back-to-back DATA reads with stb held on a full FIFO
    wb_write(A_CTRL, 32'h1, 4'hF);
    repeat (6) @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_DATA; sel = 4'hF;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_level_full", {29'd0, level}, 32'd4);
      check("b2b_ack_alternates", {31'd0, ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (ack) begin
        if (acks > 0) check("b2b_sequence", rdat, xs(prev));
        prev = rdat;
        acks++;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    check("b2b_ack_count", acks, 32'd4);

    // Out-of-block access: no ack, no effect
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h10; dat = 32'h3; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mismatch_no_ack", {31'd0, ack}, 32'h0);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    wb_read(A_STAT, r); check("mismatch_status", r, 32'h0000_0012);
    wb_read(A_CTRL, r); check("mismatch_ctrl", r, 32'h0000_0001);

    // Flush with EN kept on: empty at ack edge, refill next cycle
    wb_write(A_CTRL, 32'h3, 4'h1);
    check("flush_level_zero", {29'd0, level}, 32'd0);
    @(negedge clk);
    check("refill_level_one", {29'd0, level}, 32'd1);

    // Reset mid-transaction
    repeat (2) @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_DATA; sel = 4'hF;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1'b1;
    end
    check("pre_reset_ack_seen", {31'd0, got}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_ack", {31'd0, ack}, 32'h0);
    check("async_reset_dat", rdat, 32'h0);
    check("async_reset_level", {29'd0, level}, 32'h0);
    repeat (2) @(negedge clk);
    check("reset_held_no_ack", {31'd0, ack}, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    rst_n = 1'b1;
    wb_read(A_STAT, r); check("rereset_status", r, 32'h0000_0001);
    wb_read(A_SEED, r); check("rereset_seed", r, 32'hACE1_2468);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prng_wb_fifo.md
# prng_wb_fifo

Wishbone-attached front end for the pseudo-random number generator in the Caravel user area. It holds a single-cycle xorshift32 generator and a 4-deep output FIFO. It exposes control, seed, data and status registers to the management SoC over the wrapper's Wishbone slave port. It sits directly between the Caravel Wishbone bus and the PRNG datapath, supplying random words to firmware on demand.

## Interface
- BASE_ADDR, 32'h3000_0000: register block base; decoded on wbs_adr_i[31:4].
- SEED_DEFAULT, 32'hACE1_2468: generator state after reset; must be non-zero.
- wb_clk_i  in  1  system clock; all state changes on its rising edge.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lane selects.
- wbs_adr_i  in  32  byte address; register index is wbs_adr_i[3:2].
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  registered read data.
- rnd_level_o  out  3  FIFO occupancy 0..4, for the logic analyzer.

## Operation
- Registers (offset from BASE_ADDR):
  - 0x0 CTRL: bit0 EN (R/W); bit1 FLUSH (write-1 pulse, reads 0). Only byte lane 0 is honoured.
  - 0x4 SEED: a write loads the generator state from the sel-merged value (unselected bytes keep the current state) and flushes the FIFO. A merged value of 0 loads 32'h0000_0001. A read returns the current state.
  - 0x8 DATA: a read returns the FIFO head and pops it. A read while empty returns 0 and sets UNDERFLOW. Writes are ignored.
  - 0xC STATUS: bit0 EMPTY, bit1 FULL, bits[4:2] COUNT, bit5 UNDERFLOW (sticky; write 1 to bit5 clears it).
- Generator: next = xorshift32(state) with shifts <<13, >>17, <<5, computed in one cycle, 32-bit truncating.
  - When EN=1 and the FIFO has room (count<4, or a pop occurs in the same cycle), next is pushed and state<=next on that edge.
  - Otherwise state holds.
- FIFO: 4 entries, 2-bit wrapping read/write pointers plus a 3-bit count.
  - Push and pop in the same cycle leaves count unchanged, including when full.
  - FLUSH or a SEED write zeroes the pointers and count. No push occurs on that edge.
- Bus FSM, two states:
  - IDLE: if cyc&stb and address matches, perform the access on this edge, assert ack, and go to ACK.
  - ACK: deassert ack and return to IDLE. No back-to-back acks; a master holding stb is served every second cycle.
  - Address mismatch: no ack, no side effect.
  - Offsets within the block outside the four registers do not occur (the 2-bit index covers all).
- Reset values: wbs_ack_o=0, wbs_dat_o=0, rnd_level_o=0, EN=0, UNDERFLOW=0, FIFO empty, state=SEED_DEFAULT.
- Reset asserted mid-transaction aborts it; no ack is issued for that request.

## Timing
- Write accepted at edge T (ack high during T..T+1). CTRL/SEED effects are visible from edge T.
- After a SEED write at T with EN=1, the first push happens at T+1, value xorshift32(seed).
- Read data is registered at edge T and valid while ack is high. DATA pop and STATUS snapshot occur at T.
- The generator fills the FIFO from empty in 4 consecutive cycles with EN=1.
- STATUS read in the same cycle as a generator push reports the pre-edge count.
- rnd_level_o is registered and equals COUNT.

## Test plan
- Reset: drive wb_rst_ni low mid-cycle -> all outputs 0 immediately. STATUS reads 0x01; SEED reads 0xACE12468.
- Write SEED=0x1, then CTRL=0x1; wait 6 cycles -> STATUS=0x12 (FULL, COUNT=4). DATA reads return 0x00042021, then 0x04080601.
- With FIFO empty and EN=0, read DATA -> returns 0, STATUS bit5=1. Write STATUS=0x20 -> bit5 cleared.
- Write SEED=0 -> SEED reads 0x00000001; FIFO empty.
- Write SEED with sel=4'b0001, data 0xFF -> low byte is replaced and the other bytes are kept. FIFO is flushed.
- With the FIFO full and EN=1, issue back-to-back DATA reads with stb held -> ack every 2nd cycle and COUNT stays 4. Successive values follow the xorshift32 sequence with no gaps.
- Access at BASE_ADDR+0x10 -> no ack, no state change. CTRL write 0x3 with a full FIFO -> FIFO empty at the ack edge, refills on the next cycle.
